// File: rtl/wb_pkg.sv
// Shared types and width defaults for the wb_master_ctrl slice.
package wb_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } wb_state_e;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] dat;
        logic                      err;
        logic                      timeout;
    } wb_rsp_t;

endpackage

// File: rtl/wb_master_ctrl_if.sv
// Command, response and Wishbone signal bundle; master = controller side, slave = environment side.
interface wb_master_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = wb_pkg::DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = wb_pkg::DEF_DATA_WIDTH,
    parameter int unsigned SEL_WIDTH  = DATA_WIDTH / 8
);

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_we_i;
    logic [ADDR_WIDTH-1:0] cmd_adr_i;
    logic [DATA_WIDTH-1:0] cmd_dat_i;
    logic [SEL_WIDTH-1:0]  cmd_sel_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_dat_o;
    logic                  rsp_err_o;
    logic                  rsp_timeout_o;

    logic                  cyc_o;
    logic                  stb_o;
    logic                  we_o;
    logic [ADDR_WIDTH-1:0] adr_o;
    logic [DATA_WIDTH-1:0] dat_o;
    logic [SEL_WIDTH-1:0]  sel_o;
    logic [DATA_WIDTH-1:0] dat_i;
    logic                  ack_i;
    logic                  err_i;
    logic                  stall_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
        input  dat_i, ack_i, err_i, stall_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
        output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
        output dat_i, ack_i, err_i, stall_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
        input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o
    );

endinterface

// File: rtl/wb_watchdog.sv
// Saturating ack-wait counter; expired flags the last permitted cycle while enabled.
module wb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/wb_master_ctrl.sv
// Single-outstanding Wishbone master: command in, one bus cycle, one response out.
// Optional ack timeout enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_ctrl
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    wb_master_ctrl_if.master bus
);

    wb_state_e             state;
    logic                  cmd_ready_q;
    logic                  rsp_valid_q;
    logic                  cyc_q;
    logic                  stb_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    wb_rsp_t               rsp_q;

    logic accept;
    logic bus_done;
    logic wd_expired;

    assign accept = (state == ST_IDLE) && bus.cmd_valid_i && cmd_ready_q;
    // A stalled strobe has not been taken by the slave, so ack/err only count once it is accepted.
    assign bus_done = (bus.ack_i || bus.err_i) &&
                      ((state == ST_WAIT) || ((state == ST_REQ) && !bus.stall_i));

`ifdef WB_MASTER_TIMEOUT_EN
    logic busy;
    assign busy = (state == ST_REQ) || (state == ST_WAIT);

    wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (accept),
        .enable (busy),
        .expired(wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_q       <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        state       <= ST_REQ;
                        cmd_ready_q <= 1'b0;
                        cyc_q       <= 1'b1;
                        stb_q       <= 1'b1;
                        we_q        <= bus.cmd_we_i;
                        adr_q       <= bus.cmd_adr_i;
                        dat_q       <= bus.cmd_dat_i;
                        sel_q       <= bus.cmd_sel_i;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (bus_done) begin
                        state         <= ST_RESP;
                        cyc_q         <= 1'b0;
                        stb_q         <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_q.err     <= bus.err_i;
                        rsp_q.timeout <= 1'b0;
                        rsp_q.dat     <= (we_q || bus.err_i) ? '0 : bus.dat_i;
                    end else if (wd_expired) begin
                        state         <= ST_RESP;
                        cyc_q         <= 1'b0;
                        stb_q         <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_q.err     <= 1'b0;
                        rsp_q.timeout <= 1'b1;
                        rsp_q.dat     <= '0;
                    end else if ((state == ST_REQ) && !bus.stall_i) begin
                        state <= ST_WAIT;
                        stb_q <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready_i) begin
                        state       <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready_o   = cmd_ready_q;
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_dat_o     = rsp_q.dat;
    assign bus.rsp_err_o     = rsp_q.err;
    assign bus.rsp_timeout_o = rsp_q.timeout;
    assign bus.cyc_o         = cyc_q;
    assign bus.stb_o         = stb_q;
    assign bus.we_o          = we_q;
    assign bus.adr_o         = adr_q;
    assign bus.dat_o         = dat_q;
    assign bus.sel_o         = sel_q;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Self-checking bench for wb_master_ctrl: vector table, random traffic, reset and timeout sequences.
module tb_wb_master_ctrl;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned LOOP_MAX = 200;
`ifdef WB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef enum int {K_ACK, K_ERR, K_BOTH, K_NONE} kind_e;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int unsigned stall_n;
        int unsigned wait_n;
        kind_e       kind;
        int unsigned hold;
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_master_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4)) bus ();

    wb_master_ctrl #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .SEL_WIDTH     (4),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : 32'h0;
    endfunction

    // Model of the transaction outcome from the command and slave behaviour alone.
    task automatic model(input vec_t v, output logic [31:0] e_dat, output logic e_err);
        logic timed_out;
        timed_out = TO_EN && (v.kind == K_NONE || (v.stall_n + v.wait_n + 1) > TIMEOUT);
        e_err = (v.kind != K_ACK);
        e_dat = (!v.we && v.kind == K_ACK) ? ref_rd(v.adr) : 32'h0;
        if (!timed_out && v.we && v.kind == K_ACK)
            ref_mem[v.adr] = merge(ref_rd(v.adr), v.dat, v.sel);
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int unsigned resp_idx, exp_idx, exp_stb, i, stb_cnt;
        logic        timed_out, done;
        logic [31:0] e_dat;
        logic        e_err, e_to;
        logic [127:0] snap;

        resp_idx  = v.stall_n + v.wait_n + 1;
        timed_out = TO_EN && (v.kind == K_NONE || resp_idx > TIMEOUT);
        exp_idx   = timed_out ? TIMEOUT + 1 : resp_idx + 1;
        exp_stb   = (timed_out && v.stall_n + 1 > TIMEOUT) ? TIMEOUT : v.stall_n + 1;
        e_dat     = timed_out ? 32'h0 : v.exp_dat;
        e_err     = timed_out ? 1'b0 : v.exp_err;
        e_to      = timed_out;

        @(negedge clk);
        check({tag, "_cmd_ready"}, {127'h0, bus.cmd_ready_o}, 128'h1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = v.we;
        bus.cmd_adr_i   = v.adr;
        bus.cmd_dat_i   = v.dat;
        bus.cmd_sel_i   = v.sel;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = ~v.we;
        bus.cmd_adr_i   = $urandom;
        bus.cmd_dat_i   = $urandom;
        bus.cmd_sel_i   = 4'($urandom);

        i = 1; stb_cnt = 0; done = 1'b0;
        while (!done) begin
            bus.ack_i = 1'b0; bus.err_i = 1'b0; bus.stall_i = 1'b0; bus.dat_i = $urandom;
            if (bus.rsp_valid_o || i > LOOP_MAX) begin
                done = 1'b0 | 1'b1;
            end else begin
                check({tag, "_bus"},
                      {56'h0, bus.cmd_ready_o, bus.cyc_o, bus.stb_o, bus.we_o, bus.sel_o, bus.adr_o, bus.dat_o},
                      {56'h0, 1'b0, 1'b1, (i <= v.stall_n + 1), v.we, v.sel, v.adr, v.dat});
                if (bus.stb_o) stb_cnt++;
                bus.stall_i = (i <= v.stall_n);
                if (!timed_out && i == resp_idx) begin
                    bus.ack_i = (v.kind == K_ACK || v.kind == K_BOTH);
                    bus.err_i = (v.kind == K_ERR || v.kind == K_BOTH);
                    if (v.kind == K_ACK && !v.we) bus.dat_i = slv_rd(bus.adr_o);
                    if (v.kind == K_ACK && v.we)
                        slave_mem[bus.adr_o] = merge(slv_rd(bus.adr_o), bus.dat_o, bus.sel_o);
                end
                @(negedge clk);
                i++;
            end
        end

        check({tag, "_latency"}, 128'(i), 128'(exp_idx));
        check({tag, "_stb_cycles"}, 128'(stb_cnt), 128'(exp_stb));
        snap = {92'h0, bus.rsp_valid_o, bus.cyc_o, bus.stb_o, bus.cmd_ready_o,
                bus.rsp_err_o, bus.rsp_timeout_o, bus.rsp_dat_o};
        check({tag, "_rsp"}, snap, {92'h0, 1'b1, 1'b0, 1'b0, 1'b0, e_err, e_to, e_dat});

        // Hold the response while a stray ack/err is driven; nothing may move.
        for (int h = 0; h < int'(v.hold); h++) begin
            bus.ack_i = 1'b1; bus.err_i = 1'($urandom); bus.dat_i = $urandom;
            @(negedge clk);
            check({tag, "_hold"},
                  {92'h0, bus.rsp_valid_o, bus.cyc_o, bus.stb_o, bus.cmd_ready_o,
                   bus.rsp_err_o, bus.rsp_timeout_o, bus.rsp_dat_o}, snap);
        end
        bus.ack_i = 1'b0; bus.err_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        check({tag, "_release"}, {126'h0, bus.rsp_valid_o, bus.cmd_ready_o}, 128'h1);
    endtask

    task automatic check_reset_state(input string tag);
        check(tag, {29'h0, bus.cmd_ready_o, bus.rsp_valid_o, bus.cyc_o, bus.stb_o, bus.we_o,
                    bus.adr_o, bus.dat_o, bus.sel_o, bus.rsp_dat_o, bus.rsp_err_o, bus.rsp_timeout_o},
              128'h0);
    endtask

    vec_t tbl [9];

    initial begin
        logic [31:0] e_dat;
        logic        e_err;
        vec_t        v;

        tbl[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, K_ACK,  0, 32'h0,        1'b0};
        tbl[1] = '{1'b0, 32'h10, 32'h0,        4'hF, 3, 0, K_ACK,  0, 32'hDEADBEEF, 1'b0};
        tbl[2] = '{1'b1, 32'h20, 32'h12345678, 4'h3, 0, 2, K_ACK,  1, 32'h0,        1'b0};
        tbl[3] = '{1'b0, 32'h20, 32'h0,        4'hF, 0, 1, K_ACK,  0, 32'h00005678, 1'b0};
        tbl[4] = '{1'b0, 32'h10, 32'h0,        4'hF, 0, 0, K_BOTH, 0, 32'h0,        1'b1};
        tbl[5] = '{1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 1, 1, K_ERR,  0, 32'h0,        1'b1};
        tbl[6] = '{1'b0, 32'h10, 32'h0,        4'hF, 1, 2, K_ACK,  5, 32'hDEADBEEF, 1'b0};
        tbl[7] = '{1'b0, 32'h30, 32'h0,        4'hF, 0, 0, K_ACK,  0, 32'h0,        1'b0};
        tbl[8] = '{1'b0, 32'h10, 32'h0,        4'hF, 0, 40, K_ACK, 0, 32'hDEADBEEF, 1'b0};

        bus.cmd_valid_i = 1'b0; bus.cmd_we_i = 1'b0; bus.cmd_adr_i = '0;
        bus.cmd_dat_i = '0; bus.cmd_sel_i = '0; bus.rsp_ready_i = 1'b0;
        bus.dat_i = '0; bus.ack_i = 1'b0; bus.err_i = 1'b0; bus.stall_i = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_state("reset_state");
        rst_n = 1'b1;
        #1 check("ready_before_edge", {127'h0, bus.cmd_ready_o}, 128'h0);
        @(negedge clk);
        check("ready_after_edge", {127'h0, bus.cmd_ready_o}, 128'h1);

        // Stray ack/err while idle must not start anything.
        bus.ack_i = 1'b1; bus.err_i = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ack_ignored", {125'h0, bus.cmd_ready_o, bus.rsp_valid_o, bus.cyc_o}, 128'h4);
        bus.ack_i = 1'b0; bus.err_i = 1'b0;

        for (int k = 0; k < 9; k++) begin
            model(tbl[k], e_dat, e_err);
            run_txn(tbl[k], $sformatf("vec%0d", k));
        end

        for (int k = 0; k < 30; k++) begin
            v.we      = 1'($urandom);
            v.adr     = 32'h10 + 32'(($urandom % 5) * 4);
            v.dat     = $urandom;
            v.sel     = 4'($urandom_range(1, 15));
            v.stall_n = $urandom_range(0, 3);
            v.wait_n  = $urandom_range(0, 3);
            case ($urandom % 10)
                0:       v.kind = K_ERR;
                1:       v.kind = K_BOTH;
                default: v.kind = K_ACK;
            endcase
            v.hold = $urandom_range(0, 3);
            model(v, e_dat, e_err);
            v.exp_dat = e_dat;
            v.exp_err = e_err;
            run_txn(v, $sformatf("rnd%0d", k));
        end

`ifdef WB_MASTER_TIMEOUT_EN
        v = '{1'b0, 32'h40, 32'h0, 4'hF, 0, 0, K_NONE, 2, 32'h0, 1'b0};
        model(v, e_dat, e_err);
        run_txn(v, "timeout_wait");
        v = '{1'b1, 32'h44, 32'h1, 4'hF, 20, 0, K_NONE, 0, 32'h0, 1'b0};
        model(v, e_dat, e_err);
        run_txn(v, "timeout_stall");
`endif

        // Reset while waiting for ack: transaction dropped, no response.
        @(negedge clk);
        bus.cmd_valid_i = 1'b1; bus.cmd_we_i = 1'b1; bus.cmd_adr_i = 32'h40;
        bus.cmd_dat_i = 32'h55AA55AA; bus.cmd_sel_i = 4'hF;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        @(negedge clk);
        check("wait_entered", {126'h0, bus.cyc_o, bus.stb_o}, 128'h2);
        rst_n = 1'b0;
        #1 check_reset_state("mid_wait_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_before_edge2", {127'h0, bus.cmd_ready_o}, 128'h0);
        @(negedge clk);
        check("ready_after_release", {126'h0, bus.cmd_ready_o, bus.rsp_valid_o}, 128'h2);
        bus.ack_i = 1'b1;
        @(negedge clk);
        bus.ack_i = 1'b0;
        check("no_stale_response", {126'h0, bus.rsp_valid_o, bus.cyc_o}, 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
